dmac_master_mc: RTL and testbench
=================================

// Module: dmac_master_mc
// PURPOSE
//  Multi-channel AHB-Lite DMA master. Successor to the single-channel engine:
//  NCH independent channels, parametrised counter widths, round-robin
//  per-element arbitration. Sits behind the DMAC register file and drives
//  the system AHB-Lite bus as its only master port.
// PARAMETERS
//  NCH   2  number of channels (1..8)
//  CW    8  width of bsize/bcount and the per-channel counters
//  NIRQ  8  number of peripheral request lines; IW = $clog2(NIRQ)
// PORTS
//  HCLK    in   1        clock
//  HRESET  in   1        synchronous, active-high reset
//  HADDR   out  32       AHB address
//  HTRANS  out  2        AHB transfer type (IDLE=00, NONSEQ=10 only)
//  HSIZE   out  3        AHB size
//  HWRITE  out  1        AHB write
//  HWDATA  out  32       AHB write data
//  HREADY  in   1        AHB ready
//  HRDATA  in   32       AHB read data
//  saddr,daddr  in  NCH*32   per-channel source/destination start address
//  ssize,dsize  in  NCH*3    per-channel element size (0=B,1=H,2=W)
//  sinc,dinc    in  NCH*3    per-channel address increment in bytes, unsigned
//  bsize,bcount in  NCH*CW   elements per block minus 1, blocks minus 1
//  irqsrc  in   NCH*IW   pirq line gating each channel
//  wfi     in   NCH      1: each element waits for pirq[irqsrc]
//  start   in   NCH      one-cycle arm pulse
//  pirq    in   NIRQ     level peripheral requests
//  done    out  NCH      one-cycle pulse on final element completion
//  busy    out  NCH      channel armed, not yet done
// BEHAVIOUR
//  - Reset: HTRANS=00, HADDR=0, HWRITE=0, HSIZE=3'b010, HWDATA=0, done=0,
//    busy=0, all counters/addresses 0, FSM=IDLE, RR pointer=0.
//    Reset mid-transfer aborts all channels; no further NONSEQ is issued.
//  - start[i] with busy[i]=0: latch SA=saddr, DA=daddr, CB=bsize, CR=bcount
//    into channel i; busy[i]=1 next cycle. start[i] while busy[i]=1 ignored.
//  - Eligible(i) = busy[i] & (~wfi[i] | pirq[irqsrc[i]]).
//  - FSM: IDLE -> ARB when any channel eligible; ARB grants the eligible
//    channel first at/after RR pointer, pointer <= grant+1 (mod NCH);
//    ARB -> LD0 -> LD1 (hold until HREADY) -> ST0 -> ST1 (hold until
//    HREADY) -> UPD -> IDLE.
//  - LD0/ST0 are one-cycle address phases: HTRANS=10, HADDR=SA/DA,
//    HSIZE=ssize/dsize, HWRITE=0/1. All other states HTRANS=00.
//  - LD1 & HREADY: D <= lane-aligned HRDATA (byte/half selected by SA[1:0],
//    replicated across 32 bits); SA += sinc. ST1: HWDATA=D; on HREADY DA += dinc.
//  - UPD: if CB!=0, CB--; else if CR!=0, CR--, CB=bsize; else done[i]=1
//    for one cycle, busy[i]=0 next cycle. Per channel: (bsize+1)*(bcount+1)
//    elements.
//  - Arbitration granularity is one element; channels interleave. Address
//    arithmetic wraps modulo 2^32.
//  - start[j] arriving for another channel during a transfer is latched
//    normally; it joins arbitration at the next ARB.
// CONFIGURATION
//  DMAC_ICR_EN defined: adds ports icra/icrv (in, NCH*32 each); when
//    wfi[i]=1, ARB -> ICR0 -> ICR1 (hold until HREADY) -> LD0, ICR0 issuing
//    NONSEQ word write to icra[i], ICR1 driving HWDATA=icrv[i] (request clear).
//  Not defined: ports absent, ARB -> LD0 always.
// TESTING
//  1. ch0 start, saddr=0x100, daddr=0x200, size=2, inc=4, bsize=3, bcount=1,
//     wfi=0 -> 8 reads then writes, last write 0x21C, done[0] one pulse.
//  2. ch0 and ch1 started same cycle, bsize=1, bcount=0 -> grants alternate
//     0,1,0,1; both done pulses observed, ch1 done last.
//  3. ssize=0, saddr=0x103, HRDATA=0xAABBCCDD, dsize=0 -> HWDATA=0xAAAAAAAA.
//  4. wfi=1, irqsrc=5, pirq=0 for 20 cycles -> HTRANS=00 throughout; pirq[5]=1
//     -> transfer starts; with DMAC_ICR_EN, write of icrv to icra precedes load.
//  5. HREADY low 3 cycles in LD1 and ST1 -> FSM holds, SA/DA step once each.
//  6. HRESET asserted in ST1 -> next cycle HTRANS=00, busy=0, no done pulse.

Source files
------------

// File: rtl/dmac_master_mc.sv
// dmac_master_mc: multi-channel AHB-Lite DMA master, round-robin per element; DMAC_ICR_EN adds a request-clear write before wfi loads
module dmac_master_mc #(
  parameter int NCH = 2,
  parameter int CW = 8,
  parameter int NIRQ = 8,
  localparam int IW = $clog2(NIRQ),
  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              HCLK,
  input  logic              HRESET,
  output logic [31:0]       HADDR,
  output logic [1:0]        HTRANS,
  output logic [2:0]        HSIZE,
  output logic              HWRITE,
  output logic [31:0]       HWDATA,
  input  logic              HREADY,
  input  logic [31:0]       HRDATA,
  input  logic [NCH*32-1:0] saddr,
  input  logic [NCH*32-1:0] daddr,
  input  logic [NCH*3-1:0]  ssize,
  input  logic [NCH*3-1:0]  dsize,
  input  logic [NCH*3-1:0]  sinc,
  input  logic [NCH*3-1:0]  dinc,
  input  logic [NCH*CW-1:0] bsize,
  input  logic [NCH*CW-1:0] bcount,
  input  logic [NCH*IW-1:0] irqsrc,
  input  logic [NCH-1:0]    wfi,
  input  logic [NCH-1:0]    start,
  input  logic [NIRQ-1:0]   pirq,
`ifdef DMAC_ICR_EN
  input  logic [NCH*32-1:0] icra,
  input  logic [NCH*32-1:0] icrv,
`endif
  output logic [NCH-1:0]    done,
  output logic [NCH-1:0]    busy
);
  typedef enum logic [3:0] {IDLE, ARB, ICR0, ICR1, LD0, LD1, ST0, ST1, UPD} state_t;
  state_t st, nxt;
  logic [31:0] sa [NCH];
  logic [31:0] da [NCH];
  logic [CW-1:0] cb [NCH];
  logic [CW-1:0] cr [NCH];
  logic [2:0] ssz [NCH];
  logic [2:0] dsz [NCH];
  logic [2:0] sin [NCH];
  logic [2:0] din [NCH];
  logic [CW-1:0] bsz [NCH];
  logic [IW-1:0] irq [NCH];
  logic [31:0] ica [NCH];
  logic [31:0] icv [NCH];
  logic [31:0] d, lane, shb, shh;
  logic [GW-1:0] gnt, rr, sel, idx;
  logic [NCH-1:0] elig;
  logic last;
  // unpack the flat per-channel configuration buses
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ssz[i] = ssize[i*3 +: 3];
      dsz[i] = dsize[i*3 +: 3];
      sin[i] = sinc[i*3 +: 3];
      din[i] = dinc[i*3 +: 3];
      bsz[i] = bsize[i*CW +: CW];
      irq[i] = irqsrc[i*IW +: IW];
`ifdef DMAC_ICR_EN
      ica[i] = icra[i*32 +: 32];
      icv[i] = icrv[i*32 +: 32];
`else
      ica[i] = '0;
      icv[i] = '0;
`endif
    end
  end
  // a channel competes when armed and, if gated, its request line is high
  always_comb begin
    for (int i = 0; i < NCH; i++) elig[i] = busy[i] & (~wfi[i] | pirq[irq[i]]);
  end
  // pick the first eligible channel at or after the round-robin pointer
  always_comb begin
    sel = rr;
    idx = rr;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = GW'((int'(rr) + k) % NCH);
      if (elig[idx]) sel = idx;
    end
  end
  // byte/half lanes chosen by the low source address bits, replicated to 32 bits
  assign shb = HRDATA >> {sa[gnt][1:0], 3'b000};
  assign shh = HRDATA >> {sa[gnt][1], 4'b0000};
  assign lane = (ssz[gnt] == 3'd0) ? {4{shb[7:0]}} : (ssz[gnt] == 3'd1) ? {2{shh[15:0]}} : HRDATA;
  assign last = (cb[gnt] == '0) && (cr[gnt] == '0);
  // state register
  always_ff @(posedge HCLK) st <= HRESET ? IDLE : nxt;
  // element sequencing: arbitrate, optional request clear, load, store, update
  always_comb begin
    nxt = st;
    case (st)
      IDLE: nxt = |elig ? ARB : IDLE;
`ifdef DMAC_ICR_EN
      ARB:  nxt = ~|elig ? IDLE : wfi[sel] ? ICR0 : LD0;
      ICR0: nxt = ICR1;
      ICR1: nxt = HREADY ? LD0 : ICR1;
`else
      ARB:  nxt = ~|elig ? IDLE : LD0;
`endif
      LD0:  nxt = LD1;
      LD1:  nxt = HREADY ? ST0 : LD1;
      ST0:  nxt = ST1;
      ST1:  nxt = HREADY ? UPD : ST1;
      UPD:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // bus outputs decoded from state and granted channel
  always_comb begin
    HTRANS = (st == LD0 || st == ST0 || st == ICR0) ? 2'b10 : 2'b00;
    HWRITE = (st == ST0 || st == ICR0);
    HADDR = (st == LD0) ? sa[gnt] : (st == ST0) ? da[gnt] : (st == ICR0) ? ica[gnt] : 32'd0;
    HSIZE = (st == LD0) ? ssz[gnt] : (st == ST0) ? dsz[gnt] : 3'b010;
    HWDATA = (st == ST1) ? d : (st == ICR1) ? icv[gnt] : 32'd0;
    done = '0;
    done[gnt] = (st == UPD) && last;
  end
  // channel arming, address stepping, element/block counting
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      busy <= '0;
      gnt <= '0;
      rr <= '0;
      d <= '0;
      for (int i = 0; i < NCH; i++) begin
        sa[i] <= '0;
        da[i] <= '0;
        cb[i] <= '0;
        cr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (start[i] && !busy[i]) begin
          sa[i] <= saddr[i*32 +: 32];
          da[i] <= daddr[i*32 +: 32];
          cb[i] <= bsize[i*CW +: CW];
          cr[i] <= bcount[i*CW +: CW];
          busy[i] <= 1'b1;
        end
      end
      if (st == ARB && |elig) begin
        gnt <= sel;
        rr <= (sel == GW'(NCH - 1)) ? '0 : sel + 1'b1;
      end
      if (st == LD1 && HREADY) begin
        d <= lane;
        sa[gnt] <= sa[gnt] + {29'd0, sin[gnt]};
      end
      if (st == ST1 && HREADY) da[gnt] <= da[gnt] + {29'd0, din[gnt]};
      if (st == UPD) begin
        if (cb[gnt] != '0) cb[gnt] <= cb[gnt] - 1'b1;
        else if (cr[gnt] != '0) begin
          cr[gnt] <= cr[gnt] - 1'b1;
          cb[gnt] <= bsz[gnt];
        end else busy[gnt] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dmac_master_mc.sv
// tb_dmac_master_mc: scoreboard bench for the multi-channel DMA master (default build)
module tb_dmac_master_mc;
  localparam int NCH = 2, CW = 8, NIRQ = 8, IW = 3;
  logic HCLK = 0, HRESET = 1;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0] HTRANS;
  logic [2:0] HSIZE;
  logic HWRITE, HREADY = 1;
  logic [NCH*32-1:0] saddr = '0, daddr = '0;
  logic [NCH*3-1:0] ssize = '0, dsize = '0, sinc = '0, dinc = '0;
  logic [NCH*CW-1:0] bsize = '0, bcount = '0;
  logic [NCH*IW-1:0] irqsrc = '0;
  logic [NCH-1:0] wfi = '0, start = '0, done, busy;
  logic [NIRQ-1:0] pirq = '0;

  typedef struct packed {logic w; logic [2:0] sz; logic [31:0] a; logic [31:0] d;} bus_t;
  bus_t exp_q[$], obs_q[$], pend;
  logic pend_w = 0;
  logic [31:0] dlog = 0;
  int vecs = 0, errs = 0, nonidle = 0, wcnt = 0;
  logic ws_en = 0, fix_en = 0;
  logic [31:0] raddr = 0, fix_val = 0;

  dmac_master_mc #(.NCH(NCH), .CW(CW), .NIRQ(NIRQ)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
    .saddr(saddr), .daddr(daddr), .ssize(ssize), .dsize(dsize), .sinc(sinc), .dinc(dinc),
    .bsize(bsize), .bcount(bcount), .irqsrc(irqsrc), .wfi(wfi), .start(start),
    .pirq(pirq), .done(done), .busy(busy));

  always #5 HCLK = ~HCLK;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic bus_t tr(input logic w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] dd);
    return {w, sz, a, dd};
  endfunction

  // read data follows the last read address; garbage while stalled
  assign HRDATA = fix_en ? fix_val : HREADY ? mem(raddr) : 32'hDEADBEEF;

  // slave: remembers read address, optionally inserts 3 wait states per data phase
  always @(posedge HCLK) begin
    #1;
    if (HTRANS == 2'b10 && !HWRITE) raddr = HADDR;
    if (ws_en) begin
      if (HTRANS == 2'b10) begin
        HREADY = 0;
        wcnt = 3;
      end else if (wcnt > 0) wcnt--;
      else HREADY = 1;
    end
  end

  // monitor: records completed bus transfers and done pulses
  always @(negedge HCLK) begin
    if (HRESET) begin
      pend_w = 0;
      dlog = 0;
      obs_q.delete();
    end else begin
      if (HTRANS != 2'b00) nonidle++;
      if (pend_w && HREADY) begin
        pend.d = HWDATA;
        obs_q.push_back(pend);
        pend_w = 0;
      end
      if (HTRANS == 2'b10) begin
        if (HWRITE) begin
          pend = tr(1'b1, HSIZE, HADDR, 32'd0);
          pend_w = 1;
        end else obs_q.push_back(tr(1'b0, HSIZE, HADDR, 32'd0));
      end
      for (int i = 0; i < NCH; i++) if (done[i]) dlog = {dlog[27:0], 4'(i + 1)};
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset;
    HRESET = 1; start = '0; wfi = '0; pirq = '0; HREADY = 1; ws_en = 0; fix_en = 0;
    exp_q.delete();
    tick(2);
    HRESET = 0;
  endtask

  task automatic cfg(input int ch, input logic [31:0] s, input logic [31:0] dd, input logic [2:0] sz_s,
                     input logic [2:0] sz_d, input logic [2:0] si, input logic [2:0] di,
                     input logic [7:0] bs, input logic [7:0] bc);
    saddr[ch*32 +: 32] = s; daddr[ch*32 +: 32] = dd;
    ssize[ch*3 +: 3] = sz_s; dsize[ch*3 +: 3] = sz_d;
    sinc[ch*3 +: 3] = si; dinc[ch*3 +: 3] = di;
    bsize[ch*CW +: CW] = bs; bcount[ch*CW +: CW] = bc;
  endtask

  task automatic go(input logic [NCH-1:0] m);
    start = m;
    tick();
    start = '0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy !== '0 && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) begin
      vecs++; errs++;
      $display("FAIL %s_timeout busy=%b required 0", nm, busy);
    end
    tick(2);
  endtask

  task automatic test_reset;
    HRESET = 1;
    tick(2);
    vecs++; if (HTRANS !== 2'b00) begin errs++; $display("FAIL rst_htrans got %b required 00", HTRANS); end
    vecs++; if (HADDR !== 32'd0) begin errs++; $display("FAIL rst_haddr got %h required 0", HADDR); end
    vecs++; if (HWRITE !== 1'b0) begin errs++; $display("FAIL rst_hwrite got %b required 0", HWRITE); end
    vecs++; if (HSIZE !== 3'b010) begin errs++; $display("FAIL rst_hsize got %b required 010", HSIZE); end
    vecs++; if (HWDATA !== 32'd0) begin errs++; $display("FAIL rst_hwdata got %h required 0", HWDATA); end
    vecs++; if (done !== 2'b00) begin errs++; $display("FAIL rst_done got %b required 00", done); end
    vecs++; if (busy !== 2'b00) begin errs++; $display("FAIL rst_busy got %b required 00", busy); end
    HRESET = 0;
  endtask

  task automatic test_single;
    bus_t e, o;
    do_reset();
    cfg(0, 32'h100, 32'h200, 3'd2, 3'd2, 3'd4, 3'd4, 8'd3, 8'd1);
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(tr(1'b0, 3'd2, 32'h100 + 4 * k, 32'd0));
      exp_q.push_back(tr(1'b1, 3'd2, 32'h200 + 4 * k, mem(32'h100 + 4 * k)));
    end
    go(2'b01);
    wait_idle("single");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.size() > 0 ? obs_q.pop_front() : 'x;
      vecs++; if (o !== e) begin errs++; $display("FAIL single_bus got %h required %h", o, e); end
    end
    vecs++; if (obs_q.size() != 0) begin errs++; $display("FAIL single_extra got %0d required 0", obs_q.size()); end
    vecs++; if (dlog !== 32'h1) begin errs++; $display("FAIL single_done got %h required 1", dlog); end
  endtask

  task automatic test_interleave;
    bus_t e, o;
    do_reset();
    cfg(0, 32'h1000, 32'h2000, 3'd2, 3'd2, 3'd4, 3'd4, 8'd1, 8'd0);
    cfg(1, 32'h3000, 32'h4000, 3'd2, 3'd2, 3'd4, 3'd4, 8'd1, 8'd0);
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 2; c++) begin
        exp_q.push_back(tr(1'b0, 3'd2, 32'h1000 + 32'h2000 * c + 4 * k, 32'd0));
        exp_q.push_back(tr(1'b1, 3'd2, 32'h2000 + 32'h2000 * c + 4 * k, mem(32'h1000 + 32'h2000 * c + 4 * k)));
      end
    go(2'b11);
    wait_idle("interleave");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.size() > 0 ? obs_q.pop_front() : 'x;
      vecs++; if (o !== e) begin errs++; $display("FAIL interleave_bus got %h required %h", o, e); end
    end
    vecs++; if (obs_q.size() != 0) begin errs++; $display("FAIL interleave_extra got %0d required 0", obs_q.size()); end
    vecs++; if (dlog !== 32'h12) begin errs++; $display("FAIL interleave_done got %h required 12", dlog); end
  endtask

  task automatic test_lane;
    bus_t e, o;
    do_reset();
    fix_en = 1; fix_val = 32'hAABBCCDD;
    cfg(0, 32'h103, 32'h50, 3'd0, 3'd0, 3'd1, 3'd1, 8'd1, 8'd0);
    exp_q.push_back(tr(1'b0, 3'd0, 32'h103, 32'd0));
    exp_q.push_back(tr(1'b1, 3'd0, 32'h50, 32'hAAAAAAAA));
    exp_q.push_back(tr(1'b0, 3'd0, 32'h104, 32'd0));
    exp_q.push_back(tr(1'b1, 3'd0, 32'h51, 32'hDDDDDDDD));
    go(2'b01);
    wait_idle("lane");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.size() > 0 ? obs_q.pop_front() : 'x;
      vecs++; if (o !== e) begin errs++; $display("FAIL lane_bus got %h required %h", o, e); end
    end
    vecs++; if (dlog !== 32'h1) begin errs++; $display("FAIL lane_done got %h required 1", dlog); end
    fix_en = 0;
  endtask

  task automatic test_wfi;
    bus_t e, o;
    int n0;
    do_reset();
    irqsrc = {3'd5, 3'd0};
    wfi = 2'b10;
    pirq = 8'hDF;
    cfg(1, 32'h500, 32'h600, 3'd2, 3'd2, 3'd4, 3'd4, 8'd0, 8'd0);
    n0 = nonidle;
    go(2'b10);
    tick(20);
    vecs++; if (nonidle != n0) begin errs++; $display("FAIL wfi_idle got %0d active cycles required 0", nonidle - n0); end
    vecs++; if (busy !== 2'b10) begin errs++; $display("FAIL wfi_busy got %b required 10", busy); end
    exp_q.push_back(tr(1'b0, 3'd2, 32'h500, 32'd0));
    exp_q.push_back(tr(1'b1, 3'd2, 32'h600, mem(32'h500)));
    pirq = 8'hFF;
    wait_idle("wfi");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.size() > 0 ? obs_q.pop_front() : 'x;
      vecs++; if (o !== e) begin errs++; $display("FAIL wfi_bus got %h required %h", o, e); end
    end
    vecs++; if (dlog !== 32'h2) begin errs++; $display("FAIL wfi_done got %h required 2", dlog); end
  endtask

  task automatic test_wait_states;
    bus_t e, o;
    do_reset();
    ws_en = 1;
    cfg(0, 32'h700, 32'h800, 3'd2, 3'd2, 3'd4, 3'd0, 8'd1, 8'd0);
    dinc[2:0] = 3'd7;
    exp_q.push_back(tr(1'b0, 3'd2, 32'h700, 32'd0));
    exp_q.push_back(tr(1'b1, 3'd2, 32'h800, mem(32'h700)));
    exp_q.push_back(tr(1'b0, 3'd2, 32'h704, 32'd0));
    exp_q.push_back(tr(1'b1, 3'd2, 32'h807, mem(32'h704)));
    go(2'b01);
    wait_idle("wait");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.size() > 0 ? obs_q.pop_front() : 'x;
      vecs++; if (o !== e) begin errs++; $display("FAIL wait_bus got %h required %h", o, e); end
    end
    vecs++; if (dlog !== 32'h1) begin errs++; $display("FAIL wait_done got %h required 1", dlog); end
    ws_en = 0;
    HREADY = 1;
  endtask

  task automatic test_reset_mid;
    int n = 0, n0;
    do_reset();
    cfg(0, 32'h900, 32'hA00, 3'd2, 3'd2, 3'd4, 3'd4, 8'd3, 8'd0);
    go(2'b01);
    while (!(HTRANS == 2'b10 && HWRITE) && n < 200) begin
      tick();
      n++;
    end
    vecs++; if (n >= 200) begin errs++; $display("FAIL midrst_store got no store phase required one"); end
    tick();
    HREADY = 0;
    HRESET = 1;
    tick();
    vecs++; if (HTRANS !== 2'b00) begin errs++; $display("FAIL midrst_htrans got %b required 00", HTRANS); end
    vecs++; if (busy !== 2'b00) begin errs++; $display("FAIL midrst_busy got %b required 00", busy); end
    vecs++; if (done !== 2'b00) begin errs++; $display("FAIL midrst_done got %b required 00", done); end
    HRESET = 0;
    HREADY = 1;
    n0 = nonidle;
    tick(10);
    vecs++; if (nonidle != n0) begin errs++; $display("FAIL midrst_quiet got %0d active cycles required 0", nonidle - n0); end
    vecs++; if (dlog !== 32'h0) begin errs++; $display("FAIL midrst_nodone got %h required 0", dlog); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_interleave();
    test_lane();
    test_wfi();
    test_wait_states();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
